// File: rtl/soc_irq_pkg.sv
// Shared definitions for the SoC interrupt controller: source count,
// register word addresses and the priority helper used to form int_id.
package soc_irq_pkg;

    localparam int NUM_IRQ = 4;
    localparam int ID_W    = 2;

    localparam logic [1:0] IRQ_ADDR_PENDING = 2'd0;
    localparam logic [1:0] IRQ_ADDR_MASK    = 2'd1;
    localparam logic [1:0] IRQ_ADDR_RAW     = 2'd2;
    localparam logic [1:0] IRQ_ADDR_ID      = 2'd3;

    // Bit 0 has the highest priority; an empty vector encodes as 0.
    function automatic logic [ID_W-1:0] lowest_set(input logic [NUM_IRQ-1:0] v);
        logic [ID_W-1:0] r;
        r = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (v[i]) r = ID_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt source: multi-flop synchroniser, one history flop and the
// edge/level request select.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_MODE   = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic src,
    output logic sync,
    output logic req
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    // NOTE: non-blocking assignments let every stage sample the previous
    // stage's old value, which is what makes this a shift chain.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: synchroniser and history flops are reset too, so a source
            // held high through reset shows up as a fresh rising edge.
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], src};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign sync = chain[SYNC_STAGES-1];
    assign req  = EDGE_MODE ? (sync & ~prev) : sync;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller feeding the core's INT vector: per-source detection,
// pending/mask register window, acknowledge and priority-encoded ID.
module irq_ctrl
    import soc_irq_pkg::*;
#(
    parameter int                 NUM_SRC     = 4,
    parameter logic [NUM_SRC-1:0] EDGE_MODE   = 4'b1111,
    parameter int                 SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               we,
    input  logic               re,
    input  logic [1:0]         addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    input  logic               int_ack,
    input  logic [ID_W-1:0]    int_ack_id,
    output logic [NUM_SRC-1:0] INT,
    output logic [ID_W-1:0]    int_id,
    output logic               int_any
);

    logic [NUM_SRC-1:0] raw;
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] pending_next;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] active;
    logic [31:0]        rd_mux;

    // Upper write-data bits have no storage behind them.
    logic unused_wdata;
    assign unused_wdata = ^wdata[31:NUM_SRC];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        irq_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES),
            .EDGE_MODE  (EDGE_MODE[i])
        ) u_sync (
            .clk (clk),
            .rst (rst),
            .src (irq_src[i]),
            .sync(raw[i]),
            .req (req[i])
        );
    end

    assign active = pending & mask;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        clr    = '0;
        rd_mux = '0;
        if (we && addr == IRQ_ADDR_PENDING) clr = wdata[NUM_SRC-1:0];
        if (int_ack) clr[int_ack_id] = 1'b1;
        // Set after clear: a new request wins over W1C or ack in the same cycle.
        pending_next = (pending & ~clr) | req;

        case (addr)
            IRQ_ADDR_PENDING: rd_mux[NUM_SRC-1:0] = pending;
            IRQ_ADDR_MASK:    rd_mux[NUM_SRC-1:0] = mask;
            IRQ_ADDR_RAW:     rd_mux[NUM_SRC-1:0] = raw;
            IRQ_ADDR_ID:      rd_mux = {27'b0, int_any, 2'b0, int_id};
            default:          rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pending <= '0;
            mask    <= '0;
            INT     <= '0;
            int_any <= 1'b0;
            int_id  <= '0;
            rdata   <= '0;
        end else begin
            pending <= pending_next;
            if (we && addr == IRQ_ADDR_MASK) mask <= wdata[NUM_SRC-1:0];
            INT     <= active;
            int_any <= |active;
            int_id  <= lowest_set(active);
            // Read mux sees pre-write state, so read-during-write returns old data.
            if (re) rdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios with literal expectations, then random
// traffic, all compared every cycle against a behavioural model of two configs.
module tb_irq_ctrl;

    localparam int S = 2;

    logic        clk;
    logic        rst;
    logic [3:0]  irq_src;
    logic        we;
    logic        re;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        int_ack;
    logic [1:0]  int_ack_id;

    logic [31:0] d_rdata [2];
    logic [3:0]  d_int   [2];
    logic [1:0]  d_id    [2];
    logic        d_any   [2];

    int n_checks = 0;
    int n_errors = 0;
    bit started  = 1'b0;

    irq_ctrl u_edge (
        .clk(clk), .rst(rst), .irq_src(irq_src), .we(we), .re(re), .addr(addr),
        .wdata(wdata), .rdata(d_rdata[0]), .int_ack(int_ack), .int_ack_id(int_ack_id),
        .INT(d_int[0]), .int_id(d_id[0]), .int_any(d_any[0])
    );

    irq_ctrl #(.EDGE_MODE(4'b1110)) u_lvl (
        .clk(clk), .rst(rst), .irq_src(irq_src), .we(we), .re(re), .addr(addr),
        .wdata(wdata), .rdata(d_rdata[1]), .int_ack(int_ack), .int_ack_id(int_ack_id),
        .INT(d_int[1]), .int_id(d_id[1]), .int_any(d_any[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: hist[i][k] is irq_src as sampled k edges ago (zeros
    // after reset); the synchronised view lags S-1 edges, its history S edges.
    logic [3:0]  edge_cfg [2];
    logic [3:0]  hist     [2][S+1];
    logic [3:0]  m_pend   [2];
    logic [3:0]  m_mask   [2];
    logic [3:0]  m_int    [2];
    logic [1:0]  m_id     [2];
    logic        m_any    [2];
    logic [31:0] m_rdata  [2];

    initial begin
        edge_cfg[0] = 4'b1111;
        edge_cfg[1] = 4'b1110;
    end

    function automatic logic [1:0] first_one(input logic [3:0] v);
        for (int b = 0; b < 4; b++) if (v[b]) return 2'(b);
        return 2'd0;
    endfunction

    task automatic model_step(input int i);
        logic [3:0] sy, pv, rq, cl, act;
        if (!rst) begin
            m_pend[i] = '0; m_mask[i] = '0; m_int[i] = '0;
            m_id[i] = '0; m_any[i] = 1'b0; m_rdata[i] = '0;
            for (int k = 0; k <= S; k++) hist[i][k] = '0;
        end else begin
            sy  = hist[i][S-1];
            pv  = hist[i][S];
            rq  = (sy & ~edge_cfg[i]) | (sy & ~pv & edge_cfg[i]);
            act = m_pend[i] & m_mask[i];
            if (re) begin
                case (addr)
                    2'd0: m_rdata[i] = {28'b0, m_pend[i]};
                    2'd1: m_rdata[i] = {28'b0, m_mask[i]};
                    2'd2: m_rdata[i] = {28'b0, sy};
                    default: m_rdata[i] = {27'b0, m_any[i], 2'b0, m_id[i]};
                endcase
            end
            cl = '0;
            if (we && addr == 2'd0) cl = wdata[3:0];
            if (int_ack) cl = cl | (4'b0001 << int_ack_id);
            m_int[i] = act;
            m_any[i] = (act != 0);
            m_id[i]  = first_one(act);
            m_pend[i] = (m_pend[i] & ~cl) | rq;
            if (we && addr == 2'd1) m_mask[i] = wdata[3:0];
            for (int k = S; k > 0; k--) hist[i][k] = hist[i][k-1];
            hist[i][0] = irq_src;
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) model_step(i);
        if (!rst) started = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("model INT[%0d]", i), 32'(d_int[i]), 32'(m_int[i]));
                check($sformatf("model int_id[%0d]", i), 32'(d_id[i]), 32'(m_id[i]));
                check($sformatf("model int_any[%0d]", i), 32'(d_any[i]), 32'(m_any[i]));
                check($sformatf("model rdata[%0d]", i), d_rdata[i], m_rdata[i]);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wdata = d;
        cyc(1);
        we = 1'b0;
    endtask

    task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
        re = 1'b1; addr = a;
        cyc(1);
        re = 1'b0;
        check(name, d_rdata[0], exp);
    endtask

    task automatic ack(input logic [1:0] id);
        int_ack = 1'b1; int_ack_id = id;
        cyc(1);
        int_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b0; irq_src = '0; we = 1'b0; re = 1'b0; addr = '0;
        wdata = '0; int_ack = 1'b0; int_ack_id = '0;
        cyc(2);
        rst = 1'b1;
        check("reset INT", 32'(d_int[0]), 32'h0);
        check("reset int_id", 32'(d_id[0]), 32'h0);
        check("reset int_any", 32'(d_any[0]), 32'h0);
        check("reset rdata", d_rdata[0], 32'h0);

        // Single-cycle pulse on src2: INT exactly 3 edges after sampling.
        wr(2'd1, 32'hF);
        irq_src = 4'b0100;
        cyc(1);
        irq_src = 4'b0000;
        cyc(2);
        check("latency INT before", 32'(d_int[0]), 32'h0);
        cyc(1);
        check("latency INT", 32'(d_int[0]), 32'h4);
        check("latency int_id", 32'(d_id[0]), 32'h2);
        check("latency int_any", 32'(d_any[0]), 32'h1);
        rd("pending src2", 2'd0, 32'h4);
        rd("id register", 2'd3, 32'h12);

        // Masked source stays pending; unmasking reaches INT one cycle later.
        wr(2'd0, 32'hF);
        wr(2'd1, 32'h0);
        irq_src = 4'b0010;
        cyc(1);
        irq_src = 4'b0000;
        cyc(4);
        check("masked INT", 32'(d_int[0]), 32'h0);
        rd("masked pending", 2'd0, 32'h2);
        wr(2'd1, 32'h2);
        check("unmask same edge", 32'(d_int[0]), 32'h0);
        cyc(1);
        check("unmask INT", 32'(d_int[0]), 32'h2);

        // Priority and acknowledge.
        wr(2'd0, 32'hF);
        wr(2'd1, 32'hF);
        irq_src = 4'b1001;
        cyc(1);
        irq_src = 4'b0000;
        cyc(4);
        check("prio INT", 32'(d_int[0]), 32'h9);
        check("prio int_id", 32'(d_id[0]), 32'h0);
        ack(2'd0);
        cyc(1);
        check("ack INT", 32'(d_int[0]), 32'h8);
        check("ack int_id", 32'(d_id[0]), 32'h3);

        // W1C in the same cycle as a new src3 request: set wins.
        wr(2'd0, 32'hF);
        irq_src = 4'b1000;
        cyc(1);
        irq_src = 4'b0000;
        cyc(1);
        wr(2'd0, 32'h8);
        rd("set wins", 2'd0, 32'h8);
        wr(2'd0, 32'h2);
        rd("w1c idle bit", 2'd0, 32'h8);

        // Level source 0 on u_lvl re-pends while held; edge source does not.
        wr(2'd0, 32'hF);
        irq_src = 4'b0001;
        cyc(4);
        check("level hold INT", 32'(d_int[1]), 32'h1);
        ack(2'd0);
        cyc(1);
        check("level ack held", 32'(d_int[1]), 32'h1);
        check("edge ack cleared", 32'(d_int[0]), 32'h0);
        irq_src = 4'b0000;
        cyc(3);
        ack(2'd0);
        cyc(1);
        check("level ack dropped", 32'(d_int[1]), 32'h0);

        // Reset mid-operation with src2 held through it.
        wr(2'd0, 32'hF);
        irq_src = 4'b1111;
        cyc(1);
        irq_src = 4'b0100;
        cyc(4);
        check("pre-reset INT", 32'(d_int[0]), 32'hF);
        rst = 1'b0;
        cyc(1);
        rst = 1'b1;
        check("mid reset INT", 32'(d_int[0]), 32'h0);
        check("mid reset int_any", 32'(d_any[0]), 32'h0);
        rd("mid reset mask", 2'd1, 32'h0);
        rd("mid reset pending", 2'd0, 32'h0);
        wr(2'd1, 32'h4);
        check("post reset INT early", 32'(d_int[0]), 32'h0);
        cyc(1);
        check("post reset INT", 32'(d_int[0]), 32'h4);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 5) == 0) irq_src[b] = ~irq_src[b];
            end
            we         = ($urandom_range(0, 3) == 0);
            re         = ($urandom_range(0, 1) == 0);
            addr       = 2'($urandom);
            wdata      = $urandom;
            int_ack    = ($urandom_range(0, 3) == 0);
            int_ack_id = 2'($urandom);
            rst        = ($urandom_range(0, 299) != 0);
            cyc(1);
        end
        rst = 1'b1; we = 1'b0; re = 1'b0; int_ack = 1'b0;
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
